// File: rtl/irom_loader.sv
// irom_loader: clears the instruction ROM to NOP, then streams a host program
// into it from address 0 while holding the node core halted.
//
// Host handshake: a word transfers on a rising CLK edge when in_valid and
// in_ready are both high. in_ready depends only on the current state, never on
// in_valid. in_data and in_last are sampled only on a transfer. Words accepted
// after the ROM is full are consumed and dropped.
module irom_loader #(
    parameter int IROM_SIZE = 16,
    parameter int PC_W      = 4,
    parameter int INSTR_W   = 16
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               start,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_data,
    input  logic               in_last,
    output logic               in_ready,
    output logic               iwen,
    output logic [PC_W-1:0]    iaddr,
    output logic [INSTR_W-1:0] idata,
    output logic               node_halt,
    output logic               busy,
    output logic               done,
    output logic               err_overflow,
    output logic [PC_W:0]      prog_len
);

    localparam int CNT_W = PC_W + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IROM_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        LOAD   = 3'd2,
        DRAIN  = 3'd3,
        FINISH = 3'd4
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [CNT_W-1:0] counter;
    logic             accept;

    assign accept = in_valid & in_ready;
    assign busy   = (state != IDLE);

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state decode plus the state-derived outputs in_ready and done.
    always_comb begin
        state_d  = state;
        in_ready = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_d = CLEAR;
            end
            CLEAR: begin
                if (counter == LAST_IDX) state_d = LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_last)                  state_d = FINISH;
                    else if (counter == LAST_IDX) state_d = DRAIN;
                end
            end
            DRAIN: begin
                in_ready = 1'b1;
                if (in_valid && in_last) state_d = FINISH;
            end
            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Counter, registered ROM write port, halt and status registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            counter      <= '0;
            iwen         <= 1'b0;
            iaddr        <= '0;
            idata        <= '0;
            node_halt    <= 1'b0;
            err_overflow <= 1'b0;
            prog_len     <= '0;
        end else begin
            iwen <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        counter      <= '0;
                        err_overflow <= 1'b0;
                        prog_len     <= '0;
                        node_halt    <= 1'b1;
                    end
                end
                CLEAR: begin
                    iwen  <= 1'b1;
                    iaddr <= counter[PC_W-1:0];
                    idata <= '0;
                    if (counter == LAST_IDX) counter <= '0;
                    else                     counter <= counter + 1'b1;
                end
                LOAD: begin
                    if (accept) begin
                        iwen     <= 1'b1;
                        iaddr    <= counter[PC_W-1:0];
                        idata    <= in_data;
                        counter  <= counter + 1'b1;
                        prog_len <= counter + 1'b1;
                    end
                end
                DRAIN: begin
                    // ROM is full: words are consumed but never written.
                    if (accept) err_overflow <= 1'b1;
                end
                FINISH: begin
                    node_halt <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_irom_loader.sv
// Testbench for irom_loader: directed programs, write scoreboard and a
// completion scoreboard checked by an independent monitor.
module tb_irom_loader;

    localparam int IROM_SIZE = 16;
    localparam int PC_W      = 4;
    localparam int INSTR_W   = 16;
    localparam int WR_W      = PC_W + INSTR_W;
    localparam int DN_W      = PC_W + 2;

    logic               CLK;
    logic               nRST;
    logic               start;
    logic               in_valid;
    logic [INSTR_W-1:0] in_data;
    logic               in_last;
    logic               in_ready;
    logic               iwen;
    logic [PC_W-1:0]    iaddr;
    logic [INSTR_W-1:0] idata;
    logic               node_halt;
    logic               busy;
    logic               done;
    logic               err_overflow;
    logic [PC_W:0]      prog_len;

    // Expected ROM writes {addr, data} and load results {prog_len, err}.
    logic [WR_W-1:0] exp_q[$];
    logic [DN_W-1:0] done_q[$];

    logic [INSTR_W-1:0] words [0:31];
    int total = 0;
    int bad   = 0;

    irom_loader #(.IROM_SIZE(IROM_SIZE), .PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
        .CLK(CLK), .nRST(nRST), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .iwen(iwen), .iaddr(iaddr), .idata(idata), .node_halt(node_halt),
        .busy(busy), .done(done), .err_overflow(err_overflow),
        .prog_len(prog_len)
    );

    // Clock.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: every ROM write and every done pulse is matched against the queues.
    initial begin
        logic [WR_W-1:0] w;
        logic [DN_W-1:0] d;
        forever begin
            @(negedge CLK);
            if (nRST) begin
                if (iwen) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_write", {iaddr, idata}, 32'hFFFF_FFFF);
                    end else begin
                        w = exp_q.pop_front();
                        chk("write_addr_data", {iaddr, idata}, w);
                    end
                end
                if (done) begin
                    if (done_q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        d = done_q.pop_front();
                        chk("done_prog_len", prog_len, d[DN_W-1:1]);
                        chk("done_err_overflow", err_overflow, d[0]);
                        chk("done_node_halt", node_halt, 1);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Pulse start; if the loader is idle, expect the full clear sequence.
    task automatic do_start(input bit expect_clear);
        start = 1'b1;
        tick();
        start = 1'b0;
        if (expect_clear) begin
            for (int i = 0; i < IROM_SIZE; i++) exp_q.push_back({PC_W'(i), INSTR_W'(0)});
            chk("halt_after_start", node_halt, 1);
            chk("busy_after_start", busy, 1);
            chk("err_cleared_on_start", err_overflow, 0);
            chk("len_cleared_on_start", prog_len, 0);
        end
    endtask

    // Offer one word and hold it until accepted (bounded).
    task automatic send_word(input logic [INSTR_W-1:0] data, input bit last);
        int cyc;
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        cyc = 0;
        while (!in_ready && cyc < 200) begin
            tick();
            cyc++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        tick();
    endtask

    task automatic wait_idle();
        int cyc;
        cyc = 0;
        while (busy && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("return_to_idle", busy, 0);
        chk("halt_released", node_halt, 0);
    endtask

    // Full load of n words from 'words'; gap inserts an idle cycle between words;
    // poke pulses start once during CLEAR and once during LOAD.
    task automatic run_prog(input int n, input bit gap, input bit poke);
        int exp_len;
        exp_len = (n > IROM_SIZE) ? IROM_SIZE : n;
        do_start(1'b1);
        done_q.push_back({(PC_W + 1)'(exp_len), (n > IROM_SIZE)});
        if (poke) begin
            tick();
            tick();
            do_start(1'b0);
        end
        for (int i = 0; i < n; i++) begin
            if (i < IROM_SIZE) exp_q.push_back({PC_W'(i), words[i]});
            send_word(words[i], (i == n - 1));
            if (gap || (poke && i == 1)) begin
                in_valid = 1'b0;
                if (poke && i == 1) do_start(1'b0);
                else tick();
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        wait_idle();
        tick();
        chk("writes_drained", exp_q.size(), 0);
        chk("done_seen", done_q.size(), 0);
    endtask

    initial begin
        nRST     = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        tick();
        tick();
        chk("rst_iwen", iwen, 0);
        chk("rst_halt", node_halt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_len", prog_len, 0);
        nRST = 1'b1;
        tick();
        chk("idle_ready", in_ready, 0);

        // Three-word program, in_valid held high.
        words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333;
        run_prog(3, 1'b0, 1'b0);
        chk("len_3", prog_len, 3);
        chk("err_3", err_overflow, 0);

        // Same program with in_valid toggling.
        run_prog(3, 1'b1, 1'b0);

        // Exactly full ROM: no overflow.
        for (int i = 0; i < 32; i++) words[i] = INSTR_W'(16'hA000 + i + 1);
        run_prog(16, 1'b0, 1'b0);
        chk("len_16", prog_len, 16);
        chk("err_16", err_overflow, 0);

        // One word too many.
        run_prog(17, 1'b0, 1'b0);
        chk("len_17", prog_len, 16);
        chk("err_17_sticky", err_overflow, 1);

        // Four extra words, dropped.
        run_prog(20, 1'b1, 1'b0);
        chk("err_20", err_overflow, 1);

        // Spurious starts in CLEAR and LOAD; new start clears status.
        words[0] = 16'hBEEF; words[1] = 16'h0042; words[2] = 16'h7001; words[3] = 16'hC0DE;
        run_prog(4, 1'b0, 1'b1);
        chk("len_poke", prog_len, 4);
        chk("err_poke", err_overflow, 0);

        // Asynchronous reset with counter at 5 in LOAD.
        do_start(1'b1);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back({PC_W'(i), words[i]});
            send_word(words[i], 1'b0);
        end
        in_valid = 1'b0;
        tick();
        tick();
        chk("pre_reset_drained", exp_q.size(), 0);
        chk("pre_reset_busy", busy, 1);
        #2 nRST = 1'b0;
        #1;
        chk("arst_iwen", iwen, 0);
        chk("arst_halt", node_halt, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ready", in_ready, 0);
        chk("arst_addr", iaddr, 0);
        chk("arst_len", prog_len, 0);
        @(negedge CLK);
        nRST = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'hDEAD;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_reset_ignored", {in_ready, busy}, 0);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        tick();
        chk("post_reset_no_writes", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/irom_loader.md
Name: irom_loader

Overview:
- Program loader that sits directly upstream of the node's instruction ROM, on the write side.
- Accepts a stream of instruction words from the host/programming interface over a valid/ready handshake.
- First clears the whole ROM to zero (NOP), then writes the program sequentially from address 0 through the ROM's idata/iaddr/iwen port.
- Holds the node core halted while loading, and reports program length and error status when finished.

Parameters:
- IROM_SIZE, 16, number of instruction slots in the ROM.
- PC_W, 4, address width; IROM_SIZE <= 2**PC_W.
- INSTR_W, 16, instruction word width (matches i_t).

Ports:
- CLK  input  1  clock.
- nRST  input  1  reset, asynchronous, active-low.
- start  input  1  single-cycle request to begin a load.
- in_valid  input  1  host word valid.
- in_data  input  INSTR_W  host instruction word.
- in_last  input  1  marks final word of the program; qualified by in_valid.
- in_ready  output  1  loader accepts a word this cycle.
- iwen  output  1  ROM write enable (registered).
- iaddr  output  PC_W  ROM write address (registered).
- idata  output  INSTR_W  ROM write data (registered).
- node_halt  output  1  holds the core PC/execution while high.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when a load ends, successful or not.
- err_overflow  output  1  sticky; program exceeded IROM_SIZE words.
- prog_len  output  PC_W+1  number of words written by the last load (0..IROM_SIZE).

Behaviour:
- Reset values:
  - All outputs 0, except node_halt = 0.
  - State IDLE; internal counter 0.
- States: IDLE, CLEAR, LOAD, DRAIN, FINISH.
- IDLE:
  - in_ready = 0.
  - start -> CLEAR. On the same edge: counter <= 0, err_overflow <= 0, prog_len <= 0, node_halt <= 1.
- CLEAR:
  - Each cycle: iwen <= 1, iaddr <= counter, idata <= 0, counter++.
  - After writing address IROM_SIZE-1: counter <= 0, go to LOAD.
  - CLEAR lasts exactly IROM_SIZE cycles.
  - in_ready = 0.
- LOAD:
  - in_ready = 1 (combinational from state).
  - On in_valid & in_ready:
    - iwen <= 1, iaddr <= counter, idata <= in_data.
    - counter++, prog_len <= counter+1.
  - Accepted word with in_last -> FINISH.
  - Accepted word without in_last, when counter == IROM_SIZE-1 (ROM now full) -> DRAIN.
  - No accepted word -> iwen <= 0.
- DRAIN:
  - in_ready = 1; iwen <= 0; words are discarded.
  - First discarded word sets err_overflow <= 1.
  - Accepted in_last -> FINISH.
  - Exactly IROM_SIZE words followed by in_last is an overflow: the extra word is dropped and the error is flagged.
- FINISH (one cycle):
  - done = 1, iwen <= 0, node_halt <= 0 on exit, then go to IDLE.
  - prog_len holds its value until the next start.
- Write latency: one cycle from handshake to iwen/iaddr/idata. The ROM captures the write on the following edge.
- start outside IDLE is ignored. busy = (state != IDLE).
- node_halt stays high from the start edge through FINISH, and drops on the FINISH->IDLE edge.
- in_last in LOAD with in_valid low has no effect.
- iaddr never exceeds IROM_SIZE-1. Counter arithmetic is unsigned, PC_W+1 bits.
- Asynchronous reset mid-load:
  - Immediately returns to IDLE, iwen = 0, node_halt = 0.
  - ROM contents are whatever was written so far; the ROM has its own reset.

Test Plan:
- Reset, then start, then 3 words 0x1111/0x2222/0x3333 (last on the third), in_valid held high -> 16 zero writes to addresses 0..15; then writes (0,0x1111), (1,0x2222), (2,0x3333); done pulse; prog_len = 3; err_overflow = 0; node_halt high from start until after done.
- Same program with in_valid toggled 1/0 every cycle -> identical write sequence, no duplicate or skipped addresses, iwen low on idle cycles.
- 17-word program, last on word 17 -> addresses 0..15 written with words 1..16; word 17 dropped; err_overflow = 1; prog_len = 16; done pulses once.
- 20-word program with last on word 20 -> words 17..20 accepted (in_ready = 1) and dropped; iwen never asserted after address 15; done after word 20.
- start pulsed during CLEAR and during LOAD -> ignored, sequence unchanged; new start after IDLE clears err_overflow and prog_len.
- nRST asserted while counter = 5 in LOAD -> all outputs 0 asynchronously, state IDLE; after release, in_valid is ignored until start.
